// File: rtl/imem_arb_pkg.sv
// Shared definitions for the two-port instruction-memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: requester count, requester index type, named requester indices.
package imem_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef logic [$clog2(NUM_REQ)-1:0] req_idx_t;

  localparam req_idx_t REQ_CPU = 1'b0;
  localparam req_idx_t REQ_DBG = 1'b1;

endpackage

// File: rtl/imem_rsp_slot.sv
// Per-requester response slot: tracks the outstanding read, holds ROM data on stall.
// Latency: response valid exactly one cycle after grant_i.
// Backpressure: rsp_ready_i low parks rom_q in a holding register until accepted.
// Ports:
//   clock_i, reset_i   : clock, synchronous active-high reset
//   grant_i            : this requester is granted the ROM this cycle
//   rsp_ready_i        : consumer accepts the response this cycle
//   rom_q_i            : ROM read data (valid the cycle after grant)
//   rsp_valid_o/_data_o: response to the consumer
//   eligible_o         : slot can accept a new grant this cycle
module imem_rsp_slot (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        grant_i,
  input  logic        rsp_ready_i,
  input  logic [31:0] rom_q_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        eligible_o
);

  // pend_q: ROM data for this slot is on rom_q_i now.
  // hold_q: data was not accepted when it arrived and lives in hold_dat_q.
  // The two are exclusive because a grant needs the slot to be free or draining.
  logic        pend_q, pend_d;
  logic        hold_q, hold_d;
  logic [31:0] hold_dat_q, hold_dat_d;

  assign rsp_valid_o = pend_q | hold_q;
  assign rsp_data_o  = hold_q ? hold_dat_q : rom_q_i;
  assign eligible_o  = !rsp_valid_o || rsp_ready_i;

  always_comb begin
    pend_d     = grant_i;
    hold_d     = rsp_valid_o && !rsp_ready_i;
    hold_dat_d = hold_dat_q;
    // Capture only on arrival; an already-held word stays put.
    if (pend_q && !rsp_ready_i) begin
      hold_dat_d = rom_q_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pend_q     <= 1'b0;
      hold_q     <= 1'b0;
      hold_dat_q <= '0;
    end else begin
      pend_q     <= pend_d;
      hold_q     <= hold_d;
      hold_dat_q <= hold_dat_d;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one synchronous instruction ROM between CPU and debug.
// Latency: grant combinational in the request cycle, response one cycle later.
// Backpressure: a requester with an unaccepted response is not granted; the other proceeds.
// Ports:
//   clock, reset           : clock, synchronous active-high reset
//   req_valid/req_addr0/1  : request strobes and byte addresses (0 = CPU, 1 = debug)
//   req_ready              : grant, high in the cycle a request is taken
//   rsp_valid/rsp_data0/1  : responses, rsp_ready from consumers
//   rom_address/rom_q      : synchronous ROM port
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int NBITS_TOP = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  input  logic [NBITS_TOP-1:0] req_addr0,
  input  logic [NBITS_TOP-1:0] req_addr1,
  output logic [1:0]           req_ready,
  output logic [1:0]           rsp_valid,
  output logic [31:0]          rsp_data0,
  output logic [31:0]          rsp_data1,
  input  logic [1:0]           rsp_ready,
  output logic [NBITS_TOP-1:0] rom_address,
  input  logic [31:0]          rom_q
);

  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   cand;
  req_idx_t             fav_q, fav_d;    // requester that wins a tie
  logic [NBITS_TOP-1:0] addr_q, addr_d;  // last address presented to the ROM
  logic [31:0]          slot_data [NUM_REQ];

  always_comb begin
    cand        = req_valid & eligible;
    req_ready   = '0;
    fav_d       = fav_q;
    addr_d      = addr_q;
    rom_address = addr_q;

    if (!reset) begin
      if (&cand) begin
        req_ready[fav_q] = 1'b1;
      end else begin
        req_ready = cand;
      end
    end

    // The loser of the next tie is whoever was just served.
    if (req_ready[REQ_CPU]) begin
      fav_d       = REQ_DBG;
      addr_d      = req_addr0;
      rom_address = req_addr0;
    end else if (req_ready[REQ_DBG]) begin
      fav_d       = REQ_CPU;
      addr_d      = req_addr1;
      rom_address = req_addr1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fav_q  <= REQ_CPU;
      addr_q <= '0;
    end else begin
      fav_q  <= fav_d;
      addr_q <= addr_d;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    imem_rsp_slot u_slot (
      .clock_i     (clock),
      .reset_i     (reset),
      .grant_i     (req_ready[i]),
      .rsp_ready_i (rsp_ready[i]),
      .rom_q_i     (rom_q),
      .rsp_valid_o (rsp_valid[i]),
      .rsp_data_o  (slot_data[i]),
      .eligible_o  (eligible[i])
    );
  end

  assign rsp_data0 = slot_data[REQ_CPU];
  assign rsp_data1 = slot_data[REQ_DBG];

endmodule
